// File: rtl/bram_table_writer_if.sv
// Stream-in and BRAM-side signal bundle for the S-box table writer.
// The slave modport is the writer; the master modport is the table source and BRAM.
interface bram_table_writer_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic                  start;
  logic [2*DATA_W-1:0]   in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     exp_sum;
  logic [DATA_W-1:0]     DOA;
  logic [DATA_W-1:0]     DOB;
  logic [ADDR_W-1:0]     ADDRA;
  logic [ADDR_W-1:0]     ADDRB;
  logic [DATA_W-1:0]     DIA;
  logic [DATA_W-1:0]     DIB;
  logic                  WEA;
  logic                  WEB;
  logic                  EN;
  logic                  busy;
  logic                  done;
  logic                  pass;

  modport master (
    output start, in_data, in_valid, exp_sum, DOA, DOB,
    input  in_ready, ADDRA, ADDRB, DIA, DIB, WEA, WEB, EN, busy, done, pass
  );

  modport slave (
    input  start, in_data, in_valid, exp_sum, DOA, DOB,
    output in_ready, ADDRA, ADDRB, DIA, DIB, WEA, WEB, EN, busy, done, pass
  );
endinterface

// File: rtl/bram_table_writer.sv
// Loads a masked S-box table into a dual-port BRAM two entries per cycle,
// then reads it back through both ports and checks the XOR checksum.
module bram_table_writer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  bram_table_writer_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(DEPTH / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_VERIFY,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   wcnt;
  logic [ADDR_W-1:0]   rcnt;
  logic [DATA_W-1:0]   wsum;
  logic [DATA_W-1:0]   rsum;
  logic [DATA_W-1:0]   exp_lat;
  logic [RD_LAT:0]     vld_p;

  logic                in_ready_q;
  logic [ADDR_W-1:0]   addra_q;
  logic [ADDR_W-1:0]   addrb_q;
  logic [DATA_W-1:0]   dia_q;
  logic [DATA_W-1:0]   dib_q;
  logic                wea_q;
  logic                web_q;
  logic                en_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;

  logic [DATA_W-1:0]   lo;
  logic [DATA_W-1:0]   hi;
  logic                accept;
  logic                issue;

  function automatic logic [ADDR_W-1:0] even_addr(input logic [ADDR_W-1:0] pair);
    return ADDR_W'({pair, 1'b0});
  endfunction

  function automatic logic [ADDR_W-1:0] odd_addr(input logic [ADDR_W-1:0] pair);
    return ADDR_W'({pair, 1'b1});
  endfunction

  assign lo     = bus.in_data[DATA_W-1:0];
  assign hi     = bus.in_data[2*DATA_W-1:DATA_W];
  assign accept = (state == S_WRITE) && bus.in_valid && in_ready_q;
  assign issue  = (state == S_VERIFY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      wcnt       <= '0;
      rcnt       <= '0;
      wsum       <= '0;
      rsum       <= '0;
      exp_lat    <= '0;
      vld_p      <= '0;
      in_ready_q <= 1'b0;
      addra_q    <= '0;
      addrb_q    <= '0;
      dia_q      <= '0;
      dib_q      <= '0;
      wea_q      <= 1'b0;
      web_q      <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // read tags age alongside the BRAM pipeline; the oldest one marks valid DOA/DOB
      vld_p  <= {vld_p[RD_LAT-1:0], issue};
      if (vld_p[RD_LAT]) begin
        rsum <= rsum ^ bus.DOA ^ bus.DOB;
      end

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            exp_lat    <= bus.exp_sum;
            wcnt       <= '0;
            rcnt       <= '0;
            wsum       <= '0;
            rsum       <= '0;
            pass_q     <= 1'b0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
            state      <= S_WRITE;
          end
        end

        S_WRITE: begin
          wea_q <= accept;
          web_q <= accept;
          en_q  <= accept;
          if (accept) begin
            addra_q <= even_addr(wcnt);
            addrb_q <= odd_addr(wcnt);
            dia_q   <= lo;
            dib_q   <= hi;
            wsum    <= wsum ^ lo ^ hi;
            wcnt    <= wcnt + 1'b1;
            if (wcnt == LAST_PAIR) begin
              in_ready_q <= 1'b0;
              state      <= S_VERIFY;
            end
          end
        end

        S_VERIFY: begin
          addra_q <= even_addr(rcnt);
          addrb_q <= odd_addr(rcnt);
          wea_q   <= 1'b0;
          web_q   <= 1'b0;
          en_q    <= 1'b1;
          rcnt    <= rcnt + 1'b1;
          if (rcnt == LAST_PAIR) begin
            state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          wea_q <= 1'b0;
          web_q <= 1'b0;
          // the final fold happens on this same edge when only the oldest tag remains
          if (vld_p[RD_LAT-1:0] == '0) begin
            en_q   <= 1'b0;
            done_q <= 1'b1;
            state  <= S_DONE;
          end else begin
            en_q <= 1'b1;
          end
        end

        S_DONE: begin
          pass_q <= (rsum == wsum) && (wsum == exp_lat);
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.ADDRA    = addra_q;
  assign bus.ADDRB    = addrb_q;
  assign bus.DIA      = dia_q;
  assign bus.DIB      = dib_q;
  assign bus.WEA      = wea_q;
  assign bus.WEB      = web_q;
  assign bus.EN       = en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;

endmodule

// File: tb/tb_bram_table_writer.sv
// Directed bench for bram_table_writer with a two-cycle-latency dual-port BRAM model.
`timescale 1ns/1ps
module tb_bram_table_writer;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 8;
  localparam int DEPTH    = 1024;
  localparam int RD_LAT   = 2;
  localparam int NPAIR    = DEPTH / 2;
  localparam int BASE_LAT = DEPTH + RD_LAT + 2;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  bit   flip = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bram_table_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  bram_table_writer #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // BRAM model: address at pins in cycle c gives data on DO in cycle c+2
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] sa, sb;
  logic [DATA_W-1:0] tbl [0:DEPTH-1];

  always @(posedge clk) begin
    if (bus.EN) begin
      if (bus.WEA) mem[bus.ADDRA] <= bus.DIA;
      if (bus.WEB) mem[bus.ADDRB] <= bus.DIB;
      sa      <= mem[bus.ADDRA] ^ ((flip && bus.ADDRA == ADDR_W'(700)) ? 8'h01 : 8'h00);
      sb      <= mem[bus.ADDRB] ^ ((flip && bus.ADDRB == ADDR_W'(700)) ? 8'h01 : 8'h00);
      bus.DOA <= sa;
      bus.DOB <= sb;
    end
  end

  // write-pulse address/data sequence, address hold while idle-enabled, done pulse count
  int wk = 0, wr_err = 0, hold_err = 0, dn_cnt = 0;
  logic [ADDR_W-1:0] pa = '0, pb = '0;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bus.start && !bus.busy) begin
        wk <= 0;
      end else if (bus.EN && (bus.WEA || bus.WEB)) begin
        if (wk >= NPAIR || !(bus.WEA && bus.WEB) ||
            bus.ADDRA != ADDR_W'(2*wk) || bus.ADDRB != ADDR_W'(2*wk+1) ||
            bus.DIA !== tbl[2*wk] || bus.DIB !== tbl[2*wk+1])
          wr_err <= wr_err + 1;
        wk <= wk + 1;
      end
      if (bus.busy && !bus.EN && (bus.ADDRA != pa || bus.ADDRB != pb))
        hold_err <= hold_err + 1;
      if (bus.done) dn_cnt <= dn_cnt + 1;
    end
    pa <= bus.ADDRA;
    pb <= bus.ADDRB;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] outs();
    logic [63:0] r;
    r = '0;
    r[42:0] = {bus.in_ready, bus.ADDRA, bus.ADDRB, bus.DIA, bus.DIB,
               bus.WEA, bus.WEB, bus.EN, bus.busy, bus.done, bus.pass};
    return r;
  endfunction

  function automatic int mem_mismatch();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== tbl[i]) n++;
    return n;
  endfunction

  task automatic fill(input int kind);
    for (int i = 0; i < DEPTH; i++) begin
      case (kind)
        1:       tbl[i] = 8'(i);
        default: tbl[i] = 8'h00;
      endcase
    end
    if (kind == 2) tbl[5] = 8'h3C;
  endtask

  task automatic run_op(input string tag, input logic [7:0] es, input bit stall,
                        input bit pulse, input int abort_at, input logic exp_pass);
    int k, stalls, st_cyc, dn0, lat, guard;
    bit acc, got_done;
    k = 0; stalls = 0; lat = 0; dn0 = dn_cnt;
    @(posedge clk); #1;
    bus.exp_sum = es;
    bus.start   = 1'b1;
    @(negedge clk); st_cyc = cyc;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.exp_sum = 8'hFF;
    guard = 0;
    while (k < NPAIR && guard < 20000) begin
      if (abort_at > 0 && k == abort_at) begin
        bus.in_valid = 1'b0;
        #2 rst = 1'b0;
        #1 chk({tag, "_abort_outs"}, outs(), 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        return;
      end
      bus.in_valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.in_data  = {tbl[2*k+1], tbl[2*k]};
      bus.start    = pulse && (k == 50);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (bus.in_ready && !bus.in_valid) stalls++;
      @(posedge clk); #1;
      if (acc) k++;
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    chk({tag, "_stream"}, k, NPAIR);
    if (pulse) begin
      repeat (20) @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
    end
    got_done = 1'b0; guard = 0;
    while (!got_done && guard < 4000) begin
      @(negedge clk);
      if (bus.done) begin
        got_done = 1'b1;
        lat = cyc - st_cyc;
      end
      guard++;
    end
    chk({tag, "_done_seen"}, 64'(got_done), 64'd1);
    if (got_done) begin
      chk({tag, "_latency"}, lat, BASE_LAT + stalls);
      @(negedge clk);
      chk({tag, "_pass"}, 64'(bus.pass), 64'(exp_pass));
      chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
      repeat (5) @(negedge clk);
      chk({tag, "_done_pulses"}, dn_cnt - dn0, 1);
      chk({tag, "_wr_pairs"}, wk, NPAIR);
      chk({tag, "_wr_seq"}, wr_err, 0);
      chk({tag, "_hold"}, hold_err, 0);
      chk({tag, "_mem"}, mem_mismatch(), 0);
    end
  endtask

  initial begin
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.exp_sum  = '0;
    repeat (3) @(posedge clk);
    #1 chk("reset_outs", outs(), 64'd0);
    rst = 1'b1;

    fill(0); run_op("zero",    8'h00, 1'b0, 1'b0, 0, 1'b1);
    fill(1); run_op("idx",     8'h00, 1'b0, 1'b0, 0, 1'b1);
             run_op("idx_bad", 8'h01, 1'b0, 1'b0, 0, 1'b0);
    fill(2); run_op("one",     8'h3C, 1'b0, 1'b0, 0, 1'b1);
    flip = 1'b1;
             run_op("flip",    8'h3C, 1'b0, 1'b0, 0, 1'b0);
    flip = 1'b0;
    fill(1); run_op("stall",   8'h00, 1'b1, 1'b0, 0, 1'b1);
             run_op("abort",   8'h00, 1'b0, 1'b0, 100, 1'b1);
             run_op("restart", 8'h00, 1'b0, 1'b0, 0, 1'b1);
             run_op("pulse",   8'h00, 1'b0, 1'b1, 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
